// File: rtl/manchester_rx.sv
// Oversampling Manchester decoder: locks on mid-bit edges, emits decoded bits
// and WIDTH-bit words, and flags timing violations while locked.
module manchester_rx #(
    parameter int unsigned OVS      = 8,
    parameter int unsigned WIDTH    = 8,
    parameter bit          POLARITY = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             data_m,
    output logic             data_out,
    output logic             bit_valid,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    output logic             code_err,
    output logic             locked
);

    localparam int unsigned CNT_W   = $clog2(2 * OVS + 1);
    localparam int unsigned INC_W   = CNT_W + 1;
    localparam int unsigned BIT_W   = $clog2(WIDTH + 1);
    localparam int unsigned MID_LO  = 3 * OVS / 4;
    localparam int unsigned MID_HI  = 5 * OVS / 4;
    localparam int unsigned TIMEOUT = 2 * OVS;

    typedef enum logic [1:0] {IDLE, HUNT, LOCK} state_t;

    state_t             state;
    logic               sync1, d_s, d_p;
    logic [CNT_W-1:0]   cnt;
    logic [BIT_W-1:0]   bit_cnt;
    logic [WIDTH-1:0]   shreg;
    logic               bnd_seen;

    logic               line_edge;
    logic               bit_now;
    logic [INC_W-1:0]   cnt_inc;
    logic [BIT_W-1:0]   bit_base;
    logic [BIT_W-1:0]   bit_cnt_nx;
    logic [WIDTH-1:0]   sh_base;
    logic [WIDTH-1:0]   sh_next;
    logic               word_done;

    // The first accepted bit after HUNT starts a fresh word.
    assign line_edge  = d_s ^ d_p;
    assign bit_now    = d_s ^ POLARITY;
    assign cnt_inc    = INC_W'(cnt) + INC_W'(1);
    assign bit_base   = (state == LOCK) ? bit_cnt : '0;
    assign sh_base    = (state == LOCK) ? shreg : '0;
    assign bit_cnt_nx = bit_base + BIT_W'(1);
    assign sh_next    = WIDTH'({sh_base, bit_now});
    assign word_done  = (bit_cnt_nx == BIT_W'(WIDTH));

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            sync1      <= 1'b0;
            d_s        <= 1'b0;
            d_p        <= 1'b0;
            cnt        <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            bnd_seen   <= 1'b0;
            data_out   <= 1'b0;
            bit_valid  <= 1'b0;
            word_out   <= '0;
            word_valid <= 1'b0;
            code_err   <= 1'b0;
            locked     <= 1'b0;
        end else begin
            sync1      <= data_m;
            d_s        <= sync1;
            d_p        <= d_s;
            bit_valid  <= 1'b0;
            word_valid <= 1'b0;
            code_err   <= 1'b0;

            case (state)
                IDLE: begin
                    cnt      <= '0;
                    bit_cnt  <= '0;
                    shreg    <= '0;
                    bnd_seen <= 1'b0;
                    locked   <= 1'b0;
                    if (line_edge) state <= HUNT;
                end

                HUNT: begin
                    if (line_edge && cnt_inc < INC_W'(MID_LO)) begin
                        cnt <= '0;
                    end else if (line_edge) begin
                        state     <= LOCK;
                        locked    <= 1'b1;
                        cnt       <= '0;
                        bnd_seen  <= 1'b0;
                        data_out  <= bit_now;
                        bit_valid <= 1'b1;
                        if (word_done) begin
                            word_out   <= sh_next;
                            word_valid <= 1'b1;
                            bit_cnt    <= '0;
                        end else begin
                            bit_cnt <= bit_cnt_nx;
                        end
                        shreg <= sh_next;
                    end else if (cnt_inc >= INC_W'(TIMEOUT)) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= CNT_W'(cnt_inc);
                    end
                end

                LOCK: begin
                    // Short edges are bit boundaries; only one is legal per bit.
                    if (line_edge && cnt_inc < INC_W'(MID_LO)) begin
                        if (bnd_seen) begin
                            state    <= IDLE;
                            locked   <= 1'b0;
                            code_err <= 1'b1;
                            cnt      <= '0;
                            bit_cnt  <= '0;
                            shreg    <= '0;
                            bnd_seen <= 1'b0;
                        end else begin
                            bnd_seen <= 1'b1;
                            cnt      <= CNT_W'(cnt_inc);
                        end
                    end else if (line_edge && cnt_inc <= INC_W'(MID_HI)) begin
                        cnt       <= '0;
                        bnd_seen  <= 1'b0;
                        data_out  <= bit_now;
                        bit_valid <= 1'b1;
                        if (word_done) begin
                            word_out   <= sh_next;
                            word_valid <= 1'b1;
                            bit_cnt    <= '0;
                        end else begin
                            bit_cnt <= bit_cnt_nx;
                        end
                        shreg <= sh_next;
                    end else if (cnt_inc >= INC_W'(MID_HI)) begin
                        // Last legal mid-bit slot passed without an edge.
                        state    <= IDLE;
                        locked   <= 1'b0;
                        code_err <= 1'b1;
                        cnt      <= '0;
                        bit_cnt  <= '0;
                        shreg    <= '0;
                        bnd_seen <= 1'b0;
                    end else begin
                        cnt <= CNT_W'(cnt_inc);
                    end
                end

                default: begin
                    state  <= IDLE;
                    locked <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_manchester_rx.sv
// Randomized bench for manchester_rx: builds line waveforms from bit lists and
// compares decoded bits/words/errors with values derived from the sent data.
module tb_manchester_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       data_m = 1'b0;
    logic       do0, bv0, wv0, ce0, lk0;
    logic       do1, bv1, wv1, ce1, lk1;
    logic [7:0] wo0, wo1;

    manchester_rx #(.OVS(8), .WIDTH(8), .POLARITY(1'b0)) dut0 (
        .clk(clk), .rst(rst), .data_m(data_m), .data_out(do0), .bit_valid(bv0),
        .word_out(wo0), .word_valid(wv0), .code_err(ce0), .locked(lk0)
    );

    manchester_rx #(.OVS(8), .WIDTH(8), .POLARITY(1'b1)) dut1 (
        .clk(clk), .rst(rst), .data_m(data_m), .data_out(do1), .bit_valid(bv1),
        .word_out(wo1), .word_valid(wv1), .code_err(ce1), .locked(lk1)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    // Monitor: everything observed away from the active edge.
    int         bq[$];
    logic [7:0] wq0[$], wq1[$];
    int         wcycq[$];
    int         errs0, errs1, ecyc, both_hi, saw_lock;

    always @(negedge clk) begin
        if (bv0) bq.push_back(int'(do0));
        if (wv0) begin
            wq0.push_back(wo0);
            wcycq.push_back(cyc);
        end
        if (wv1) wq1.push_back(wo1);
        if (ce0) begin
            errs0++;
            ecyc = cyc;
        end
        if (ce1) errs1++;
        if (lk0) saw_lock = 1;
        if (ce0 && bv0) both_hi++;
    end

    task automatic clear_mon();
        bq.delete(); wq0.delete(); wq1.delete(); wcycq.delete();
        errs0 = 0; errs1 = 0; ecyc = -1; both_hi = 0; saw_lock = 0;
    endtask

    // Frame model: leading 0 bit from an idle-low line, then data bits, each
    // with its own spacing from the previous mid-bit edge (IEEE: 1 = rising).
    int fbits[$];
    int fivl[$];
    int wave[$];
    int last_mid_idx;
    int last_mid_cyc;

    task automatic add_word(input int w, input int tmin, input int tmax);
        for (int b = 7; b >= 0; b--) begin
            fbits.push_back((w >> b) & 1);
            fivl.push_back(int'($urandom_range(tmax, tmin)));
        end
    endtask

    task automatic build_frame(input bit trail);
        int cur;
        int t;
        wave.delete();
        repeat (4) wave.push_back(1);
        cur = 0;
        foreach (fbits[i]) begin
            t = fivl[i];
            if (cur != fbits[i]) begin
                repeat (t) wave.push_back(cur);
            end else begin
                repeat (t / 2) wave.push_back(cur);
                repeat (t - t / 2) wave.push_back(1 - cur);
            end
            last_mid_idx = wave.size();
            cur = fbits[i];
        end
        if (trail) begin
            repeat (24) wave.push_back(cur);
            repeat (24) wave.push_back(0);
        end else begin
            wave.push_back(cur);
        end
    endtask

    task automatic play();
        foreach (wave[i]) begin
            @(negedge clk);
            data_m = (wave[i] != 0);
            if (i == last_mid_idx) last_mid_cyc = cyc;
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic new_frame();
        fbits.delete();
        fivl.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({do0, bv0, wo0, wv0, ce0, lk0} !== 13'd0) begin
            failures++;
            $display("FAIL reset_pol0 got=%0h exp=0", {do0, bv0, wo0, wv0, ce0, lk0});
        end
        checks++;
        if ({do1, bv1, wo1, wv1, ce1, lk1} !== 13'd0) begin
            failures++;
            $display("FAIL reset_pol1 got=%0h exp=0", {do1, bv1, wo1, wv1, ce1, lk1});
        end
        rst = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_a5();
        int bits_got;
        new_frame();
        add_word(8'hA5, 8, 8);
        build_frame(1'b1);
        clear_mon();
        play();
        bits_got = 0;
        foreach (bq[i]) bits_got = (bits_got << 1) | bq[i];
        checks++;
        if (bq.size() != 8 || bits_got != 8'hA5) begin
            failures++;
            $display("FAIL a5_bits got=%0h n=%0d exp=a5 n=8", bits_got, bq.size());
        end
        checks++;
        if (wq0.size() != 1 || (wq0.size() > 0 && wq0[0] !== 8'hA5)) begin
            failures++;
            $display("FAIL a5_word n=%0d got=%0h exp=a5", wq0.size(), wo0);
        end
        checks++;
        if (wq1.size() != 1 || (wq1.size() > 0 && wq1[0] !== 8'h5A)) begin
            failures++;
            $display("FAIL a5_word_pol1 n=%0d got=%0h exp=5a", wq1.size(), wo1);
        end
        checks++;
        if (wcycq.size() != 1 || (wcycq.size() > 0 && wcycq[0] - last_mid_cyc != 3)) begin
            failures++;
            $display("FAIL a5_latency got=%0d exp=3",
                     wcycq.size() > 0 ? wcycq[0] - last_mid_cyc : -1);
        end
        checks++;
        if (saw_lock != 1 || lk0 !== 1'b0 || errs0 != 1) begin
            failures++;
            $display("FAIL a5_lock saw=%0d locked=%0b errs=%0d exp=1,0,1", saw_lock, lk0, errs0);
        end
    endtask

    task automatic test_timeout();
        new_frame();
        add_word(8'hA5, 8, 8);
        fbits = fbits[0:2];
        fivl  = fivl[0:2];
        build_frame(1'b1);
        clear_mon();
        play();
        checks++;
        if (errs0 != 1 || ecyc - last_mid_cyc != 13) begin
            failures++;
            $display("FAIL timeout_err errs=%0d dt=%0d exp=1,13", errs0, ecyc - last_mid_cyc);
        end
        checks++;
        if (wq0.size() != 0 || wo0 !== 8'hA5 || lk0 !== 1'b0 || bq.size() != 3) begin
            failures++;
            $display("FAIL timeout_state words=%0d wo=%0h lk=%0b bits=%0d exp=0,a5,0,3",
                     wq0.size(), wo0, lk0, bq.size());
        end
    endtask

    task automatic test_jitter();
        int w;
        w = int'($urandom_range(255, 0)) | 8'h80;
        new_frame();
        for (int b = 7; b >= 0; b--) begin
            fbits.push_back((w >> b) & 1);
            fivl.push_back((b % 2 == 1) ? 6 : 10);
        end
        build_frame(1'b1);
        clear_mon();
        play();
        checks++;
        if (wq0.size() != 1 || (wq0.size() > 0 && wq0[0] !== 8'(w))) begin
            failures++;
            $display("FAIL jitter_word n=%0d got=%0h exp=%0h", wq0.size(), wo0, w);
        end
        checks++;
        if (errs0 != 1 || ecyc - last_mid_cyc != 13) begin
            failures++;
            $display("FAIL jitter_err errs=%0d dt=%0d exp=1,13", errs0, ecyc - last_mid_cyc);
        end

        new_frame();
        fbits = '{1, 1};
        fivl  = '{8, 5};
        build_frame(1'b1);
        clear_mon();
        play();
        checks++;
        if (errs0 != 1 || ecyc - last_mid_cyc != 3 || bq.size() != 1) begin
            failures++;
            $display("FAIL period5 errs=%0d dt=%0d bits=%0d exp=1,3,1",
                     errs0, ecyc - last_mid_cyc, bq.size());
        end

        new_frame();
        fbits = '{1, 0};
        fivl  = '{8, 11};
        build_frame(1'b1);
        clear_mon();
        play();
        checks++;
        if (errs0 != 1 || ecyc - last_mid_cyc != 2 || bq.size() != 1 || lk0 !== 1'b0) begin
            failures++;
            $display("FAIL period11 errs=%0d dt=%0d bits=%0d lk=%0b exp=1,2,1,0",
                     errs0, ecyc - last_mid_cyc, bq.size(), lk0);
        end
    endtask

    task automatic test_random_words();
        int nw, extra;
        int words[$];
        for (int it = 0; it < 4; it++) begin
            nw = int'($urandom_range(3, 1));
            extra = int'($urandom_range(7, 0));
            words.delete();
            new_frame();
            for (int k = 0; k < nw; k++) begin
                words.push_back(int'($urandom_range(255, 0)) | ((k == 0) ? 8'h80 : 8'h00));
                add_word(words[k], 6, 10);
            end
            for (int k = 0; k < extra; k++) begin
                fbits.push_back(int'($urandom_range(1, 0)));
                fivl.push_back(int'($urandom_range(10, 6)));
            end
            build_frame(1'b1);
            clear_mon();
            play();
            checks++;
            if (wq0.size() != nw || wq1.size() != nw || bq.size() != nw * 8 + extra) begin
                failures++;
                $display("FAIL rand_counts it=%0d words=%0d/%0d bits=%0d exp=%0d,%0d",
                         it, wq0.size(), wq1.size(), bq.size(), nw, nw * 8 + extra);
            end else begin
                for (int k = 0; k < nw; k++) begin
                    checks++;
                    if (wq0[k] !== 8'(words[k]) || wq1[k] !== ~8'(words[k])) begin
                        failures++;
                        $display("FAIL rand_word it=%0d k=%0d got=%0h/%0h exp=%0h",
                                 it, k, wq0[k], wq1[k], words[k]);
                    end
                end
            end
            checks++;
            if (errs0 != 1 || errs1 != 1 || both_hi != 0) begin
                failures++;
                $display("FAIL rand_err it=%0d errs=%0d/%0d both=%0d exp=1,1,0",
                         it, errs0, errs1, both_hi);
            end
        end
    endtask

    task automatic test_back_to_back();
        new_frame();
        add_word(8'hFF, 8, 8);
        add_word(8'h00, 8, 8);
        build_frame(1'b1);
        clear_mon();
        play();
        checks++;
        if (wq0.size() != 2 || (wq0.size() == 2 && (wq0[0] !== 8'hFF || wq0[1] !== 8'h00))) begin
            failures++;
            $display("FAIL b2b_words n=%0d last=%0h exp=ff,00", wq0.size(), wo0);
        end
        checks++;
        if (wcycq.size() != 2 || (wcycq.size() == 2 && wcycq[1] - wcycq[0] != 64)) begin
            failures++;
            $display("FAIL b2b_spacing got=%0d exp=64",
                     wcycq.size() == 2 ? wcycq[1] - wcycq[0] : -1);
        end
    endtask

    task automatic test_reset_midword();
        new_frame();
        add_word(8'hA5, 8, 8);
        fbits = fbits[0:4];
        fivl  = fivl[0:4];
        build_frame(1'b0);
        clear_mon();
        foreach (wave[i]) begin
            @(negedge clk);
            data_m = (wave[i] != 0);
        end
        // Reset lands on the edge that would register the fifth bit.
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({do0, bv0, wo0, wv0, ce0, lk0} !== 13'd0) begin
            failures++;
            $display("FAIL rst_mid_outputs got=%0h exp=0", {do0, bv0, wo0, wv0, ce0, lk0});
        end
        rst = 1'b0;
        repeat (8) @(negedge clk);
        checks++;
        if (bq.size() != 4 || errs0 != 0 || wq0.size() != 0 || lk0 !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_pulses bits=%0d errs=%0d words=%0d lk=%0b exp=4,0,0,0",
                     bq.size(), errs0, wq0.size(), lk0);
        end
        new_frame();
        add_word(8'hBC, 8, 8);
        build_frame(1'b1);
        clear_mon();
        play();
        checks++;
        if (wq0.size() != 1 || (wq0.size() > 0 && wq0[0] !== 8'hBC) || bq.size() != 8) begin
            failures++;
            $display("FAIL rst_mid_next n=%0d got=%0h bits=%0d exp=bc,8", wq0.size(), wo0, bq.size());
        end
    endtask

    task automatic test_ones_hunt();
        wave.delete();
        repeat (10) begin
            repeat (4) wave.push_back(0);
            repeat (4) wave.push_back(1);
        end
        repeat (24) wave.push_back(1);
        repeat (24) wave.push_back(0);
        last_mid_idx = -1;
        clear_mon();
        play();
        checks++;
        if (saw_lock != 0 || bq.size() != 0 || errs0 != 0) begin
            failures++;
            $display("FAIL ones_hunt lock=%0d bits=%0d errs=%0d exp=0,0,0", saw_lock, bq.size(), errs0);
        end
        new_frame();
        add_word(8'hA5, 8, 8);
        build_frame(1'b1);
        clear_mon();
        play();
        checks++;
        if (wq0.size() != 1 || (wq0.size() > 0 && wq0[0] !== 8'hA5) || bq.size() != 8) begin
            failures++;
            $display("FAIL ones_recover n=%0d got=%0h bits=%0d exp=a5,8", wq0.size(), wo0, bq.size());
        end
    endtask

    initial begin
        clear_mon();
        test_reset();
        test_a5();
        test_timeout();
        test_jitter();
        test_random_words();
        test_back_to_back();
        test_reset_midword();
        test_ones_hunt();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
